heading_cordic: RTL and testbench
=================================

// Module: heading_cordic
// PURPOSE
//  Parametrised successor to the level-only compass heading stage. Converts one signed
//  magnetometer X/Y sample into a 0-359 deg heading with an iterative CORDIC vectoring
//  atan2 instead of ratio-bin lookup. Adds a runtime calibration offset, decimated
//  display update and hysteresis. Sits between the sensor driver and the 7-seg display.
// PARAMETERS
//  DATA_W          16  signed width of mag_x/mag_y
//  ITER            12  CORDIC iterations, legal range 8..12
//  DEADBAND        50  |x|,|y| <= DEADBAND on both axes -> vector treated as null
//  UPDATE_INTERVAL 64  heading register updated on every Nth conversion (1 = every one)
//  HYST_DEG         2  heading changes only if circular diff > HYST_DEG
// PORTS
//  iclk          in   1       conversion clock (4 MHz domain)
//  reset         in   1       asynchronous, active-high
//  sample_valid  in   1       new X/Y sample present
//  sample_ready  out  1       high in IDLE; sample accepted when valid&&ready
//  mag_x         in   DATA_W  signed X (+X = 0 deg, North)
//  mag_y         in   DATA_W  signed Y (+Y = 90 deg, East)
//  cal_offset    in   9       calibration offset, 0..359; values >=360 treated as 0
//  raw_heading   out  9       per-conversion heading, offset applied, 0..359
//  conv_done     out  1       one-cycle pulse per completed conversion
//  heading       out  9       decimated, hysteresis-filtered heading
//  heading_valid out  1       one-cycle pulse when heading is written
// BEHAVIOUR
//  Reset: all outputs 0, sample_ready=1, FSM=IDLE, decim counter=0, first_flag=1.
//   Reset mid-conversion aborts it; no conv_done is issued.
//  FSM: IDLE -> ROTATE (ITER cycles, i=0..ITER-1) -> FINISH (1 cycle) -> IDLE.
//  IDLE: on valid&&ready, register x,y sign-extended to DATA_W+2 and cal_offset.
//   Pre-rotate: if x<0, x=-x, y=-y, z=180*16; otherwise z=0. -2^(DATA_W-1) must not overflow.
//   sample_valid is ignored outside IDLE. Nothing is queued.
//  ROTATE step i: if y>=0 {x+=y>>>i; y-=x>>>i; z+=ATAN[i]}, else the opposite signs.
//   Shifts are arithmetic. z is in 1/16 deg, signed 14 bits.
//  FINISH: if z<0, z+=5760. Round deg=(z+8)>>4. Add cal_offset; subtract 360 while
//   >=360 (at most twice). Deadband null vector -> 0 before the offset is added.
//   On the closing edge: raw_heading updates and conv_done pulses.
//   Latency: conv_done is high exactly ITER+2 cycles after the accept edge.
//   Next accept is possible in the cycle conv_done is high.
//  Decimation: counter increments on each conversion. On reaching UPDATE_INTERVAL it
//   clears and an update is considered. If first_flag is set, or
//   min(|r-h|, 360-|r-h|) > HYST_DEG: heading<=raw, heading_valid pulses with
//   conv_done, and first_flag clears. Otherwise heading holds and no pulse is issued.
//  Accuracy: |vector| >= 256 and ITER >= 10 -> within +/-1 deg of true atan2.
// STRUCTURE
//  Package heading_pkg: ATAN table in 1/16 deg
//   {720,425,225,114,57,29,14,7,4,2,1,0}, DEG360_Q4=5760, FSM state enum.
//  Sub-module cordic_vectoring (pre-rotation + ROTATE datapath, start/done handshake).
//  Top level holds FINISH wrap, decimation and hysteresis.
// TESTING
//  UI=1, off=0: (1000,0)->raw 0; (0,1000)->90; (-1000,0)->180; (0,-1000)->270.
//  UI=1: (-1000,-1000)->225+/-1; (-32768,1)->180+/-1 with no overflow; (40,-30)->0.
//  Offset/wrap: off=138, (-1000,0)->318. off=1, (1000,-17) (359.03 deg)->0, not 360.
//  Handshake: conv_done ITER+2 cycles after accept; valid held during ROTATE is
//   ignored; a back-to-back accept in the conv_done cycle is taken.
//  UI=4, HYST=2: 8 samples at 90 -> heading_valid on 4th only (first_flag). Then 4x91
//   -> no pulse. Then 4x95 -> pulse, heading=95. Then 4x(0 deg, then 358) via wrap
//   -> diff 2 -> hold.
//  Async reset at ROTATE cycle 5 -> outputs 0, no conv_done, next sample converts OK.

Source files
------------

// File: rtl/heading_pkg.sv
// Shared constants, arctangent table and FSM state type for the compass heading CORDIC.
package heading_pkg;

  localparam int Z_W       = 14;
  localparam int MAX_ITER  = 12;
  localparam int DEG360_Q4 = 5760;
  localparam int DEG180_Q4 = 2880;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_FINISH
  } state_e;

  // atan(2^-i) in 1/16 degree steps
  function automatic logic signed [Z_W-1:0] atanQ4(input logic [3:0] idx);
    case (idx)
      4'd0:    return 14'sd720;
      4'd1:    return 14'sd425;
      4'd2:    return 14'sd225;
      4'd3:    return 14'sd114;
      4'd4:    return 14'sd57;
      4'd5:    return 14'sd29;
      4'd6:    return 14'sd14;
      4'd7:    return 14'sd7;
      4'd8:    return 14'sd4;
      4'd9:    return 14'sd2;
      4'd10:   return 14'sd1;
      default: return 14'sd0;
    endcase
  endfunction

endpackage

// File: rtl/heading_cordic_vectoring.sv
// Iterative CORDIC vectoring engine: folds the vector into the right half-plane, then
// drives y to zero over ITER micro-rotations while accumulating the angle in z.
module cordic_vectoring
  import heading_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ITER   = 12
) (
  input  logic                     iclk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  output logic                     done_o,
  output logic signed [Z_W-1:0]    z_o
);

  localparam int XW = DATA_W + 2;

  logic                 busy_q;
  logic [3:0]           iter_q;
  logic signed [XW-1:0] x_q, y_q, x_d, y_d;
  logic signed [XW-1:0] xExt, yExt, xPre, yPre, xSh, ySh;
  logic signed [Z_W-1:0] z_q, z_d, zPre, atanStep;

  // Two guard bits keep the negation of the most negative sample and the CORDIC gain in range
  always_comb begin : preRotate
    xExt = {{2{x_i[DATA_W-1]}}, x_i};
    yExt = {{2{y_i[DATA_W-1]}}, y_i};
    xPre = xExt;
    yPre = yExt;
    zPre = '0;
    if (x_i[DATA_W-1]) begin
      xPre = -xExt;
      yPre = -yExt;
      zPre = Z_W'(DEG180_Q4);
    end
  end

  always_comb begin : microRotate
    xSh      = x_q >>> iter_q;
    ySh      = y_q >>> iter_q;
    atanStep = atanQ4(iter_q);
    if (!y_q[XW-1]) begin
      x_d = x_q + ySh;
      y_d = y_q - xSh;
      z_d = z_q + atanStep;
    end else begin
      x_d = x_q - ySh;
      y_d = y_q + xSh;
      z_d = z_q - atanStep;
    end
  end

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      iter_q <= '0;
      x_q    <= xPre;
      y_q    <= yPre;
      z_q    <= zPre;
    end else if (busy_q) begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      iter_q <= iter_q + 4'd1;
      if (iter_q == 4'(ITER - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  // High during the final micro-rotation; z_o is settled from the following cycle
  assign done_o = busy_q && (iter_q == 4'(ITER - 1));
  assign z_o    = z_q;

endmodule

// File: rtl/heading_cordic.sv
// Compass heading stage: CORDIC atan2 of one magnetometer sample, calibration offset,
// deadband, and a decimated, hysteresis-filtered display heading.
module heading_cordic
  import heading_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int ITER            = 12,
  parameter int DEADBAND        = 50,
  parameter int UPDATE_INTERVAL = 64,
  parameter int HYST_DEG        = 2
) (
  input  logic                     iclk,
  input  logic                     reset,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic signed [DATA_W-1:0] mag_x,
  input  logic signed [DATA_W-1:0] mag_y,
  input  logic [8:0]               cal_offset,
  output logic [8:0]               raw_heading,
  output logic                     conv_done,
  output logic [8:0]               heading,
  output logic                     heading_valid
);

  localparam int XW = DATA_W + 2;
  localparam int CW = $clog2(UPDATE_INTERVAL + 1);

  state_e          state_q;
  logic            sampleReady_q, convDone_q, headingValid_q, firstFlag_q, null_q;
  logic [8:0]      offset_q, rawHeading_q, heading_q;
  logic [CW-1:0]   decimCnt_q, decimCnt_d;
  logic [8:0]      rawHeading_d, offsetIn, degRaw, absDiff, circDiff;
  logic [9:0]      degSum;
  logic [12:0]     zPos;
  logic [XW-1:0]   absX, absY;
  logic signed [XW-1:0] xExt, yExt;
  logic signed [Z_W-1:0] zFinal;
  logic            accept, cordicDone, nullIn, decimHit, headingMove;

  assign accept = sample_valid && sampleReady_q;

  cordic_vectoring #(
    .DATA_W(DATA_W),
    .ITER  (ITER)
  ) uCordic (
    .iclk   (iclk),
    .reset  (reset),
    .start_i(accept),
    .x_i    (mag_x),
    .y_i    (mag_y),
    .done_o (cordicDone),
    .z_o    (zFinal)
  );

  always_comb begin : intake
    xExt     = {{2{mag_x[DATA_W-1]}}, mag_x};
    yExt     = {{2{mag_y[DATA_W-1]}}, mag_y};
    absX     = mag_x[DATA_W-1] ? -xExt : xExt;
    absY     = mag_y[DATA_W-1] ? -yExt : yExt;
    nullIn   = (absX <= XW'(DEADBAND)) && (absY <= XW'(DEADBAND));
    offsetIn = (cal_offset >= 9'd360) ? 9'd0 : cal_offset;
  end

  // Rounding can land exactly on 360 deg, which the offset wrap below folds back to 0
  always_comb begin : finishMath
    zPos   = zFinal[Z_W-1] ? 13'(zFinal + Z_W'(DEG360_Q4)) : 13'(zFinal);
    degRaw = 9'((zPos + 13'd8) >> 4);
    degSum = null_q ? {1'b0, offset_q} : ({1'b0, degRaw} + {1'b0, offset_q});
    if (degSum >= 10'd360) begin
      degSum = degSum - 10'd360;
    end
    if (degSum >= 10'd360) begin
      degSum = degSum - 10'd360;
    end
    rawHeading_d = degSum[8:0];
    absDiff      = (rawHeading_d >= heading_q) ? (rawHeading_d - heading_q)
                                               : (heading_q - rawHeading_d);
    circDiff     = (absDiff > 9'd180) ? (9'd360 - absDiff) : absDiff;
    headingMove  = firstFlag_q || (circDiff > 9'(HYST_DEG));
    decimCnt_d   = decimCnt_q + CW'(1);
    decimHit     = (decimCnt_d == CW'(UPDATE_INTERVAL));
  end

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sampleReady_q  <= 1'b1;
      offset_q       <= '0;
      null_q         <= 1'b0;
      rawHeading_q   <= '0;
      convDone_q     <= 1'b0;
      heading_q      <= '0;
      headingValid_q <= 1'b0;
      firstFlag_q    <= 1'b1;
      decimCnt_q     <= '0;
    end else begin
      convDone_q     <= 1'b0;
      headingValid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            offset_q      <= offsetIn;
            null_q        <= nullIn;
            sampleReady_q <= 1'b0;
            state_q       <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          if (cordicDone) begin
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          rawHeading_q  <= rawHeading_d;
          convDone_q    <= 1'b1;
          sampleReady_q <= 1'b1;
          state_q       <= ST_IDLE;
          if (decimHit) begin
            decimCnt_q <= '0;
            if (headingMove) begin
              heading_q      <= rawHeading_d;
              headingValid_q <= 1'b1;
              firstFlag_q    <= 1'b0;
            end
          end else begin
            decimCnt_q <= decimCnt_d;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          sampleReady_q <= 1'b1;
        end
      endcase
    end
  end

  assign sample_ready  = sampleReady_q;
  assign raw_heading   = rawHeading_q;
  assign conv_done     = convDone_q;
  assign heading       = heading_q;
  assign heading_valid = headingValid_q;

endmodule

// File: tb/tb_heading_cordic.sv
// Directed bench for heading_cordic: an every-conversion instance for raw headings and
// a decimating instance (UPDATE_INTERVAL=4) for the filtered heading, fed the same samples.
module tb_heading_cordic;

  localparam int ITER = 12;
  localparam int NVEC = 15;

  logic               iclk = 1'b0;
  logic               reset;
  logic               sampleValid;
  logic signed [15:0] magX, magY;
  logic [8:0]         calOffset;

  logic       readyA, doneA, hvA, readyB, doneB, hvB;
  logic [8:0] rawA, headA, rawB, headB;

  int vectors     = 0;
  int miscompares = 0;
  int lastLat, lastRaw, lastHv, lastHead;

  int vx[NVEC] = '{1000, 0, -1000, 0, -1000, -32768, 40, -1000, 1000, 0, -51, 50, 40, -50, 50};
  int vy[NVEC] = '{0, 1000, 0, -1000, -1000, 1, -30, 0, -17, 1000, 0, -50, -30, 50, 300};
  int vo[NVEC] = '{0, 0, 0, 0, 0, 0, 0, 138, 1, 500, 0, 0, 138, 359, 0};
  int ve[NVEC] = '{0, 90, 180, 270, 225, 180, 0, 318, 0, 90, 180, 0, 138, 359, 81};
  int vt[NVEC] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1};

  heading_cordic #(.ITER(ITER), .UPDATE_INTERVAL(1), .HYST_DEG(2)) dutA (
    .iclk(iclk), .reset(reset), .sample_valid(sampleValid), .sample_ready(readyA),
    .mag_x(magX), .mag_y(magY), .cal_offset(calOffset), .raw_heading(rawA),
    .conv_done(doneA), .heading(headA), .heading_valid(hvA)
  );

  heading_cordic #(.ITER(ITER), .UPDATE_INTERVAL(4), .HYST_DEG(2)) dutB (
    .iclk(iclk), .reset(reset), .sample_valid(sampleValid), .sample_ready(readyB),
    .mag_x(magX), .mag_y(magY), .cal_offset(calOffset), .raw_heading(rawB),
    .conv_done(doneB), .heading(headB), .heading_valid(hvB)
  );

  always #5 iclk = ~iclk;

  task automatic checkOutput(input string tag, input int observed, input int expected,
                             input int tol);
    int d;
    vectors++;
    d = observed - expected;
    if (d < 0) d = -d;
    if (d > tol) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
    end
  endtask

  // Returns at the negedge of the conv_done cycle, latency counted in cycles after accept
  task automatic waitDone();
    lastLat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge iclk);
      if (doneA) begin
        lastLat  = n;
        lastRaw  = int'(rawA);
        lastHv   = int'(hvB);
        lastHead = int'(headB);
        break;
      end
    end
    if (lastLat < 0) checkOutput("conv_done timeout", 0, 1, 0);
  endtask

  task automatic applyStimulus(input int x, input int y, input int off, input bit immediate);
    if (!immediate) @(negedge iclk);
    magX        = 16'(x);
    magY        = 16'(y);
    calOffset   = 9'(off);
    sampleValid = 1'b1;
    @(posedge iclk);
    #1 sampleValid = 1'b0;
    waitDone();
  endtask

  task automatic runBatch(input int x, input int y, input int n, output int mask);
    mask = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(x, y, 0, 1'b0);
      if (lastHv != 0) mask |= (1 << i);
    end
  endtask

  initial begin
    int pulses, mask, rawSeen;
    reset       = 1'b1;
    sampleValid = 1'b0;
    magX        = '0;
    magY        = '0;
    calOffset   = '0;
    repeat (3) @(negedge iclk);
    checkOutput("reset ready", int'(readyA), 1, 0);
    checkOutput("reset raw", int'(rawA), 0, 0);
    checkOutput("reset conv_done", int'(doneA), 0, 0);
    checkOutput("reset heading", int'(headB), 0, 0);
    checkOutput("reset heading_valid", int'(hvB), 0, 0);
    reset = 1'b0;

    $display("[TB] directed heading vectors");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vx[i], vy[i], vo[i], 1'b0);
      checkOutput($sformatf("raw vec%0d", i), lastRaw, ve[i], vt[i]);
      checkOutput($sformatf("latency vec%0d", i), lastLat, ITER + 2, 0);
    end

    $display("[TB] handshake");
    @(negedge iclk);
    magX = 16'sd1000; magY = 16'sd0; calOffset = 9'd0; sampleValid = 1'b1;
    @(posedge iclk);
    #1 magX = 16'sd0; magY = 16'sd1000;
    pulses  = 0;
    rawSeen = -1;
    for (int n = 1; n <= 36; n++) begin
      @(negedge iclk);
      if (n == 3) checkOutput("ready low in ROTATE", int'(readyA), 0, 0);
      if (n == 6) sampleValid = 1'b0;
      if (doneA) begin
        pulses++;
        rawSeen = int'(rawA);
      end
    end
    checkOutput("held valid conv count", pulses, 1, 0);
    checkOutput("held valid raw", rawSeen, 0, 0);

    applyStimulus(0, 1000, 0, 1'b0);
    checkOutput("b2b first raw", lastRaw, 90, 0);
    applyStimulus(0, -1000, 0, 1'b1);
    checkOutput("b2b second raw", lastRaw, 270, 0);
    checkOutput("b2b second latency", lastLat, ITER + 2, 0);

    $display("[TB] reset mid-conversion");
    @(negedge iclk);
    magX = 16'sd1000; magY = 16'sd0; sampleValid = 1'b1;
    @(posedge iclk);
    #1 sampleValid = 1'b0;
    repeat (5) @(negedge iclk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort raw", int'(rawA), 0, 0);
    checkOutput("abort ready", int'(readyA), 1, 0);
    checkOutput("abort conv_done", int'(doneA), 0, 0);
    @(negedge iclk);
    @(negedge iclk);
    reset  = 1'b0;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge iclk);
      if (doneA) pulses++;
    end
    checkOutput("abort no conv_done", pulses, 0, 0);
    applyStimulus(0, 1000, 0, 1'b0);
    checkOutput("after abort raw", lastRaw, 90, 0);

    $display("[TB] decimation and hysteresis");
    @(negedge iclk);
    reset = 1'b1;
    @(negedge iclk);
    reset = 1'b0;
    runBatch(0, 1000, 8, mask);
    checkOutput("8x90 pulse mask", mask, 8, 0);
    checkOutput("8x90 heading", lastHead, 90, 0);
    runBatch(-17, 1000, 4, mask);
    checkOutput("4x91 pulse mask", mask, 0, 0);
    checkOutput("4x91 heading", lastHead, 90, 0);
    runBatch(-87, 996, 4, mask);
    checkOutput("4x95 pulse mask", mask, 8, 0);
    checkOutput("4x95 heading", lastHead, 95, 1);
    runBatch(1000, 0, 4, mask);
    checkOutput("4x0 pulse mask", mask, 8, 0);
    checkOutput("4x0 heading", lastHead, 0, 0);
    runBatch(999, -35, 4, mask);
    checkOutput("4x358 pulse mask", mask, 0, 0);
    checkOutput("4x358 heading", lastHead, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
